sync_fifo_param: RTL and testbench

Parametrised synchronous first-word-fall-through FIFO; the buffering stage between the 32-bit host word interface and the AES-256 datapath (and its mirror on the output side). Generalises the fixed 4×32 word FIFO with configurable width/depth, correct simultaneous read/write, programmable almost-full/almost-empty thresholds, a synchronous flush and sticky overflow/underflow error flags.

---
 rtl/fifo_pkg.sv | 18 +
 rtl/fifo_mem.sv | 38 +++
 rtl/sync_fifo_param.sv | 154 +++++++++++++++
 tb/tb_sync_fifo_param.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg
//   Shared defaults and width helpers for the parametrised synchronous FIFO.
//   DEFAULT_DATA_W / DEFAULT_ADDR_W match the original 4x32 host word FIFO.
//   level_w() gives the width needed to hold an occupancy count of 0..2**addr_w.
package fifo_pkg;

    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_ADDR_W = 2;

    // Occupancy needs one bit more than the pointers so that "full" (DEPTH)
    // is distinguishable from "empty" (0).
    function automatic int level_w(input int addr_w);
        return addr_w + 1;
    endfunction

    typedef logic [DEFAULT_ADDR_W:0] level_t;

endpackage : fifo_pkg

// File: rtl/fifo_mem.sv
// fifo_mem
//   DEPTH x DATA_W register array with one synchronous write port and one
//   asynchronous read port. Contents are not reset.
//
// Ports
//   clk     in   clock, rising edge
//   we      in   write enable
//   waddr   in   write address   [ADDR_W-1:0]
//   wdata   in   write data      [DATA_W-1:0]
//   raddr   in   read address    [ADDR_W-1:0]
//   rdata   out  read data       [DATA_W-1:0], combinational from raddr
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule : fifo_mem

// File: rtl/sync_fifo_param.sv
// sync_fifo_param
//   Parametrised first-word-fall-through FIFO between the 32-bit host word
//   interface and the AES-256 datapath. Supports simultaneous read/write at
//   any level (including full), programmable almost-full / almost-empty
//   thresholds, a synchronous flush and sticky overflow/underflow flags.
//
// Ports
//   clk           in   clock, rising edge
//   resetn        in   synchronous active-low reset
//   flush         in   synchronous clear of contents (error flags kept)
//   clear_err     in   clears overflow/underflow
//   wr_en         in   write request
//   wr_data       in   write data [DATA_W-1:0]
//   rd_en         in   read request, pops the head word
//   rd_data       out  head word [DATA_W-1:0], meaningful only while !empty
//   empty         out  level == 0
//   full          out  level == DEPTH
//   almost_empty  out  level <= AEMPTY_TH
//   almost_full   out  level >= AFULL_TH
//   level         out  stored word count [ADDR_W:0], 0..DEPTH
//   overflow      out  sticky, a write was refused
//   underflow     out  sticky, a read was refused
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int DATA_W    = DEFAULT_DATA_W,
    parameter int ADDR_W    = DEFAULT_ADDR_W,
    parameter int AFULL_TH  = (1 << ADDR_W) - 1,
    parameter int AEMPTY_TH = 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              flush,
    input  logic              clear_err,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              empty,
    output logic              full,
    output logic              almost_empty,
    output logic              almost_full,
    output logic [ADDR_W:0]   level,
    output logic              overflow,
    output logic              underflow
);

    localparam int DEPTH   = 1 << ADDR_W;
    localparam int LEVEL_W = level_w(ADDR_W);

    localparam logic [LEVEL_W-1:0] DEPTH_L = LEVEL_W'(DEPTH);

    logic [ADDR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LEVEL_W-1:0] level_q,  level_d;
    logic               overflow_q,  overflow_d;
    logic               underflow_q, underflow_d;

    logic empty_s;
    logic full_s;
    logic rd_acc;
    logic wr_acc;
    logic ovf_set;
    logic udf_set;
    logic mem_we;

    // Status is a pure function of the registered level, so nothing on the
    // request inputs reaches the status outputs combinationally.
    assign empty_s = (level_q == '0);
    assign full_s  = (level_q == DEPTH_L);

    // A read frees a slot in the same cycle, which lets a write at full be
    // accepted alongside it and keeps throughput at one word per cycle.
    assign rd_acc  = rd_en & ~empty_s;
    assign wr_acc  = wr_en & (~full_s | rd_acc);
    assign ovf_set = wr_en & ~wr_acc;
    assign udf_set = rd_en & empty_s;

    // Flush and reset discard this cycle's requests, so the array must not
    // be written either.
    assign mem_we = wr_acc & ~flush & resetn;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (clear_err) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (wr_acc) begin
                wr_ptr_d = wr_ptr_q + ADDR_W'(1);
            end
            if (rd_acc) begin
                rd_ptr_d = rd_ptr_q + ADDR_W'(1);
            end
            level_d = level_q + LEVEL_W'(wr_acc) - LEVEL_W'(rd_acc);

            // Setting wins over a clear in the same cycle.
            if (ovf_set) begin
                overflow_d = 1'b1;
            end
            if (udf_set) begin
                underflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    fifo_mem #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wr_ptr_q),
        .wdata (wr_data),
        .raddr (rd_ptr_q),
        .rdata (rd_data)
    );

    assign empty        = empty_s;
    assign full         = full_s;
    assign almost_empty = (32'(level_q) <= AEMPTY_TH);
    assign almost_full  = (32'(level_q) >= AFULL_TH);
    assign level        = level_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule : sync_fifo_param

// File: tb/tb_sync_fifo_param.sv
module tb_sync_fifo_param;

    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 2;
    localparam int DEPTH     = 4;
    localparam int AFULL_TH  = 3;
    localparam int AEMPTY_TH = 1;

    logic              clk = 1'b0;
    logic              resetn;
    logic              flush;
    logic              clear_err;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              rd_en;
    logic [DATA_W-1:0] rd_data;
    logic              empty;
    logic              full;
    logic              almost_empty;
    logic              almost_full;
    logic [ADDR_W:0]   level;
    logic              overflow;
    logic              underflow;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    sync_fifo_param #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .AFULL_TH  (AFULL_TH),
        .AEMPTY_TH (AEMPTY_TH)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .flush        (flush),
        .clear_err    (clear_err),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .empty        (empty),
        .full         (full),
        .almost_empty (almost_empty),
        .almost_full  (almost_full),
        .level        (level),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Reference model: an ordered queue of stored words plus two sticky bits.
    logic [DATA_W-1:0] mq[$];
    bit m_ovf = 1'b0;
    bit m_udf = 1'b0;
    bit chk_en = 1'b0;

    always @(posedge clk) begin
        bit rd_ok, wr_ok, ov, ud;
        if (!resetn) begin
            mq.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else if (flush) begin
            mq.delete();
            if (clear_err) begin
                m_ovf = 1'b0;
                m_udf = 1'b0;
            end
        end else begin
            rd_ok = rd_en && (mq.size() > 0);
            wr_ok = wr_en && ((mq.size() < DEPTH) || rd_ok);
            ov    = wr_en && !wr_ok;
            ud    = rd_en && (mq.size() == 0);
            if (rd_ok) void'(mq.pop_front());
            if (wr_ok) mq.push_back(wr_data);
            if (clear_err) begin
                m_ovf = 1'b0;
                m_udf = 1'b0;
            end
            if (ov) m_ovf = 1'b1;
            if (ud) m_udf = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("level",        level,        64'(mq.size()));
            check("empty",        empty,        64'(mq.size() == 0));
            check("full",         full,         64'(mq.size() == DEPTH));
            check("almost_empty", almost_empty, 64'(mq.size() <= AEMPTY_TH));
            check("almost_full",  almost_full,  64'(mq.size() >= AFULL_TH));
            check("overflow",     overflow,     64'(m_ovf));
            check("underflow",    underflow,    64'(m_udf));
            if (mq.size() > 0) check("rd_data", rd_data, 64'(mq[0]));
        end
    end

    task automatic cyc(input bit w, input logic [DATA_W-1:0] d, input bit r,
                       input bit f, input bit c);
        wr_en     = w;
        wr_data   = d;
        rd_en     = r;
        flush     = f;
        clear_err = c;
        @(posedge clk);
        #1;
    endtask

    logic [DATA_W-1:0] fill_vals [4];

    initial begin
        fill_vals[0] = 32'h11; fill_vals[1] = 32'h22;
        fill_vals[2] = 32'h33; fill_vals[3] = 32'h44;
        resetn = 1'b0;
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        resetn = 1'b1;
        chk_en = 1'b1;

        // reset state
        check("rst_level", level, 0);
        check("rst_empty", empty, 1);
        check("rst_aempty", almost_empty, 1);
        check("rst_afull", almost_full, 0);
        check("rst_full", full, 0);
        check("rst_ovf", overflow, 0);
        check("rst_udf", underflow, 0);

        // fill to full, then one refused write
        for (int i = 0; i < 4; i++) cyc(1, fill_vals[i], 0, 0, 0);
        check("fill_level", level, 4);
        check("fill_full", full, 1);
        check("fill_afull", almost_full, 1);
        cyc(1, 32'h55, 0, 0, 0);
        check("ovf_set", overflow, 1);
        check("ovf_level", level, 4);
        check("ovf_head", rd_data, 32'h11);

        // drain in order, then one refused read
        cyc(0, 0, 0, 0, 1);
        check("ovf_cleared", overflow, 0);
        for (int i = 0; i < 4; i++) begin
            check("drain_data", rd_data, fill_vals[i]);
            cyc(0, 0, 1, 0, 0);
        end
        check("drain_empty", empty, 1);
        cyc(0, 0, 1, 0, 0);
        check("udf_set", underflow, 1);
        check("udf_level", level, 0);

        // simultaneous write/read at full across pointer wrap
        cyc(0, 0, 0, 0, 1);
        check("udf_cleared", underflow, 0);
        for (int i = 0; i < 4; i++) cyc(1, 32'h100 + i, 0, 0, 0);
        for (int j = 0; j < 8; j++) begin
            check("wrap_data", rd_data, 32'h100 + j);
            cyc(1, 32'h104 + j, 1, 0, 0);
            check("wrap_level", level, 4);
            check("wrap_ovf", overflow, 0);
        end
        check("wrap_head", rd_data, 32'h108);

        // write into empty with read requested
        cyc(0, 0, 0, 1, 0);
        cyc(1, 32'hA5, 1, 0, 0);
        check("wr_empty_level", level, 1);
        check("wr_empty_udf", underflow, 1);
        check("wr_empty_data", rd_data, 32'hA5);

        // flush with a write pending, error flags kept
        cyc(0, 0, 0, 1, 0);
        check("flush_keep_udf", underflow, 1);
        for (int i = 0; i < 3; i++) cyc(1, 32'h200 + i, 0, 0, 0);
        check("pre_flush_level", level, 3);
        cyc(1, 32'hDEAD, 0, 1, 0);
        check("flush_level", level, 0);
        check("flush_empty", empty, 1);
        check("flush_ovf", overflow, 0);
        check("flush_udf", underflow, 1);
        cyc(0, 0, 0, 0, 1);
        check("clr_ovf", overflow, 0);
        check("clr_udf", underflow, 0);

        // reset mid-fill
        cyc(1, 32'h61, 0, 0, 0);
        cyc(1, 32'h62, 0, 0, 0);
        check("midfill_level", level, 2);
        resetn = 1'b0;
        cyc(0, 0, 0, 0, 0);
        check("mid_rst_level", level, 0);
        check("mid_rst_empty", empty, 1);
        check("mid_rst_aempty", almost_empty, 1);
        check("mid_rst_full", full, 0);
        resetn = 1'b1;
        cyc(1, 32'h77, 0, 0, 0);
        check("post_rst_data", rd_data, 32'h77);
        check("post_rst_level", level, 1);

        // randomized traffic against the model
        for (int k = 0; k < 3000; k++) begin
            bit f, c;
            f = ($urandom_range(99) < 3);
            c = !f && ($urandom_range(99) < 5);
            resetn = ($urandom_range(199) != 0);
            cyc($urandom_range(99) < 60, $urandom, $urandom_range(99) < 50, f, c);
        end

        resetn = 1'b1;
        cyc(0, 0, 0, 0, 0);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_sync_fifo_param
